// File: rtl/sseg_score_display.sv
// sseg_score_display: multiplexed 4-digit common-anode seven-segment driver.
// Snapshots BCD on done_tick, scans digits with leading-zero suppression, dash on invalid and blinking.
module sseg_score_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done_tick,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       lz_blank,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);
  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int FC_W = $clog2(BLINK_FRAMES) + 1;
  logic [RC_W-1:0] r_rc;
  logic [1:0]      r_idx;
  logic [FC_W-1:0] r_fc;
  logic            r_phase;
  logic            r_frame_tick;
  logic [3:0][3:0] r_d;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            w_adv, w_wrap, w_fc_last, w_blank3, w_blank2, w_blank1, w_off;
  logic [3:0]      w_dig;
  logic [6:0]      w_seg;
  assign w_adv     = r_rc == RC_W'(REFRESH_DIV - 1);
  assign w_wrap    = w_adv && r_idx == 2'd3;
  assign w_fc_last = r_fc == FC_W'(BLINK_FRAMES - 1);
  // The zero-run mask stops at the first nonzero digit, so a dash (10..15) also stops it.
  assign w_blank3  = lz_blank && r_d[3] == 4'd0;
  assign w_blank2  = w_blank3 && r_d[2] == 4'd0;
  assign w_blank1  = w_blank2 && r_d[1] == 4'd0;
  assign w_off     = (r_idx == 2'd3 ? w_blank3 : r_idx == 2'd2 ? w_blank2 : r_idx == 2'd1 ? w_blank1 : 1'b0)
                   | (blink_en & ~r_phase);
  assign w_dig     = r_d[r_idx];
  always_comb begin
    case (w_dig)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rc         <= '0;
      r_idx        <= 2'd0;
      r_fc         <= '0;
      r_phase      <= 1'b1;
      r_d          <= '0;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else begin
      if (done_tick) r_d <= {bcd3, bcd2, bcd1, bcd0};
      r_rc         <= w_adv ? '0 : r_rc + 1'b1;
      r_idx        <= w_adv ? r_idx + 2'd1 : r_idx;
      r_frame_tick <= w_wrap;
      if (w_wrap) begin
        r_fc    <= w_fc_last ? '0 : r_fc + 1'b1;
        r_phase <= w_fc_last ? ~r_phase : r_phase;
      end
      r_an  <= w_off ? 4'hF : ~(4'd1 << r_idx);
      r_seg <= w_off ? 7'h7F : w_seg;
    end
  end
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = 1'b1;
  assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_sseg_score_display.sv
// tb_sseg_score_display: directed checks of scan order, decode, LZ blanking, blinking and reset.
module tb_sseg_score_display;
  logic       clk = 1'b0, reset = 1'b1, done_tick = 1'b0, lz_blank = 1'b0, blink_en = 1'b0;
  logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;
  int checks = 0, failures = 0;

  sseg_score_display #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .done_tick(done_tick),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .lz_blank(lz_blank), .blink_en(blink_en),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reset, then release with a done_tick carrying the given digits; returns at the first sample after release.
  task automatic start(input logic [3:0] a3, a2, a1, a0, input logic lz);
    @(negedge clk); reset = 1'b1; done_tick = 1'b0; lz_blank = lz; blink_en = 1'b0;
    @(negedge clk); reset = 1'b0; done_tick = 1'b1; {bcd3, bcd2, bcd1, bcd0} = {a3, a2, a1, a0};
    @(negedge clk); done_tick = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ea;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_ft: got %b want 0", frame_tick); end
    reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      ea = ~(4'd1 << (((n - 1) / 4) % 4));
      checks++; if (an !== ea) begin failures++; $display("FAIL scan_an n=%0d: got %b want %b", n, an, ea); end
      checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL scan_seg n=%0d: got %b want 1000000", n, seg); end
      checks++; if (frame_tick !== (n % 16 == 0)) begin failures++; $display("FAIL frame_tick n=%0d: got %b want %b", n, frame_tick, n % 16 == 0); end
    end
  endtask

  task automatic test_decode;
    logic [6:0] es [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [3:0] ea;
    start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL latency_old: got %b want 1000000", seg); end
    @(negedge clk);
    checks++; if (seg !== 7'b0011001) begin failures++; $display("FAIL latency_new: got %b want 0011001", seg); end
    repeat (14) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = ~(4'd1 << (i / 4));
      checks++; if (an !== ea || seg !== es[i/4]) begin failures++; $display("FAIL decode_1234 i=%0d: got an=%b seg=%b want an=%b seg=%b", i, an, seg, ea, es[i/4]); end
    end
  endtask

  task automatic test_lz;
    logic [6:0] es [4] = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    logic [3:0] ea;
    start(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = (i / 4 >= 2) ? 4'hF : ~(4'd1 << (i / 4));
      checks++; if (an !== ea || seg !== es[i/4]) begin failures++; $display("FAIL lz_0042 i=%0d: got an=%b seg=%b want an=%b seg=%b", i, an, seg, ea, es[i/4]); end
    end
    start(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = (i / 4 == 0) ? 4'b1110 : 4'hF;
      checks++; if (an !== ea || seg !== (i / 4 == 0 ? 7'b1000000 : 7'h7F)) begin failures++; $display("FAIL lz_0000 i=%0d: got an=%b seg=%b want an=%b", i, an, seg, ea); end
    end
  endtask

  task automatic test_dash;
    logic [6:0] es [4] = '{7'b0010010, 7'b1000000, 7'b0111111, 7'h7F};
    logic [3:0] ea;
    start(4'd0, 4'd10, 4'd0, 4'd5, 1'b1);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ea = (i / 4 == 3) ? 4'hF : ~(4'd1 << (i / 4));
      checks++; if (an !== ea || seg !== es[i/4]) begin failures++; $display("FAIL dash_0A05 i=%0d: got an=%b seg=%b want an=%b seg=%b", i, an, seg, ea, es[i/4]); end
    end
  endtask

  task automatic test_back_to_back;
    start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    done_tick = 1'b1; bcd0 = 4'd7;
    @(negedge clk); bcd0 = 4'd9;
    @(negedge clk); done_tick = 1'b0; bcd0 = 4'd3;
    checks++; if (seg !== 7'b1111000) begin failures++; $display("FAIL b2b_first: got %b want 1111000", seg); end
    @(negedge clk);
    checks++; if (seg !== 7'b0010000) begin failures++; $display("FAIL b2b_last: got %b want 0010000", seg); end
    repeat (13) @(negedge clk);
    checks++; if (an !== 4'b1110 || seg !== 7'b0010000) begin failures++; $display("FAIL b2b_hold: got an=%b seg=%b want an=1110 seg=0010000", an, seg); end
  endtask

  task automatic test_blink;
    logic [3:0] ea;
    start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    blink_en = 1'b1;
    for (int n = 2; n <= 100; n++) begin
      @(negedge clk);
      ea = ((n >= 33 && n <= 64) || n >= 97) ? 4'hF : ~(4'd1 << (((n - 1) / 4) % 4));
      checks++; if (an !== ea) begin failures++; $display("FAIL blink n=%0d: got %b want %b", n, an, ea); end
    end
    blink_en = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'b1101 || seg !== 7'b0110000) begin failures++; $display("FAIL blink_drop: got an=%b seg=%b want an=1101 seg=0110000", an, seg); end
  endtask

  task automatic test_mid_reset;
    logic [3:0] ea;
    start(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
    repeat (9) @(negedge clk);
    checks++; if (an !== 4'b1011 || seg !== 7'b0000010) begin failures++; $display("FAIL pre_reset: got an=%b seg=%b want an=1011 seg=0000010", an, seg); end
    reset = 1'b1; done_tick = 1'b1; {bcd3, bcd2, bcd1, bcd0} = 16'h9999;
    @(negedge clk);
    checks++; if (an !== 4'hF || seg !== 7'h7F || frame_tick !== 1'b0) begin failures++; $display("FAIL mid_reset: got an=%b seg=%b ft=%b want an=1111 seg=1111111 ft=0", an, seg, frame_tick); end
    @(negedge clk); reset = 1'b0; done_tick = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ea = ~(4'd1 << ((n - 1) / 4));
      checks++; if (an !== ea || seg !== 7'b1000000) begin failures++; $display("FAIL restart n=%0d: got an=%b seg=%b want an=%b seg=1000000", n, an, seg, ea); end
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_lz;
    test_dash;
    test_back_to_back;
    test_blink;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
